// File: rtl/rle_decoder_8.sv
// Run-length decoder: expands (pixel, run) tokens into a raster pixel stream,
// tracking the pixel position inside fixed-size blocks and counting completed blocks.
//
// Handshake contract (both ports): a beat transfers on a rising clk edge where
// valid and ready are both high. The output side holds out_pixel/out_pos/out_last
// steady while out_valid=1 and out_ready=0. in_ready is combinational and is
// never raised during reset.
module rle_decoder_8 #(
  parameter int DATA_W    = 8,
  parameter int RUN_W     = 8,
  parameter int BLOCK_LEN = 64,
  parameter int POS_W     = 6,
  parameter int BLK_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic [RUN_W-1:0]  in_run,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_last,
  output logic [BLK_W-1:0]  blocks_done,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BLOCK_LEN - 1);

  state_t             state;
  logic [RUN_W-1:0]   remaining;
  logic               run_done;
  logic               in_xfer;
  logic               out_xfer;
  logic [POS_W-1:0]   pos_next;

  // remaining counts pixels still owed after the one currently presented.
  assign run_done = (remaining == '0);
  assign out_xfer = out_valid & out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign busy     = (state == EMIT);

  // A new token may only enter as the final pixel of the current run leaves.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        in_ready = 1'b1;
      end else begin
        in_ready = out_ready & run_done;
      end
    end
  end

  always_comb begin
    pos_next = out_pos + POS_W'(1);
    if (out_pos == LAST_POS) begin
      pos_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_pixel   <= '0;
      out_pos     <= '0;
      out_last    <= 1'b0;
      blocks_done <= '0;
      remaining   <= '0;
    end else begin
      // Position advances per delivered pixel, independent of token boundaries.
      if (out_xfer) begin
        out_pos  <= pos_next;
        out_last <= (pos_next == LAST_POS);
        if (out_last) begin
          blocks_done <= blocks_done + BLK_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (in_xfer) begin
            state     <= EMIT;
            out_pixel <= in_pixel;
            remaining <= in_run;
            out_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (out_xfer) begin
            if (!run_done) begin
              remaining <= remaining - RUN_W'(1);
            end else if (in_xfer) begin
              out_pixel <= in_pixel;
              remaining <= in_run;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decoder_8.sv
// Directed bench for rle_decoder_8: reset, single run, back-to-back tokens,
// backpressure, block wrap, max run with mid-run reset.
module tb_rle_decoder_8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic [7:0]  in_run;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic [5:0]  out_pos;
  logic        out_last;
  logic [15:0] blocks_done;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  rle_decoder_8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .in_run      (in_run),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_pos     (out_pos),
    .out_last    (out_last),
    .blocks_done (blocks_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_px(input string tag, input logic [7:0] pix, input int pos, input logic last);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".pixel"}, 32'(out_pixel), 32'(pix));
    check({tag, ".pos"},   32'(out_pos),   32'(pos));
    check({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    int  rdy_pat [5];
    int  pos_pat [5];
    int  irdy_pat[5];
    int  pos;
    logic accepted;

    rdy_pat  = '{1, 0, 1, 0, 1};
    pos_pat  = '{8, 9, 9, 10, 10};
    irdy_pat = '{0, 0, 0, 0, 1};

    // Reset held two cycles with a token offered.
    rst = 1'b1; in_valid = 1'b1; in_pixel = 8'h77; in_run = 8'd0; out_ready = 1'b1;
    go();
    mid();
    check("rst.in_ready",    32'(in_ready),    32'd0);
    check("rst.out_valid",   32'(out_valid),   32'd0);
    check("rst.out_pos",     32'(out_pos),     32'd0);
    check("rst.blocks_done", 32'(blocks_done), 32'd0);
    check("rst.busy",        32'(busy),        32'd0);
    go();
    mid();
    check("rst2.in_ready",   32'(in_ready),    32'd0);
    check("rst2.out_valid",  32'(out_valid),   32'd0);
    go();
    rst = 1'b0; in_valid = 1'b0;

    // Single token 0x5A, run 3 -> four pixels.
    in_valid = 1'b1; in_pixel = 8'h5A; in_run = 8'd3;
    mid();
    check("single.idle_ready", 32'(in_ready), 32'd1);
    check("single.idle_busy",  32'(busy),     32'd0);
    go();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      expect_px($sformatf("single.px%0d", k), 8'h5A, k, 1'b0);
      check($sformatf("single.busy%0d", k), 32'(busy), 32'd1);
      go();
    end
    mid();
    check("single.end_valid", 32'(out_valid), 32'd0);
    check("single.end_busy",  32'(busy),      32'd0);
    check("single.end_pos",   32'(out_pos),   32'd4);

    // Back-to-back tokens, no bubble between runs.
    go();
    in_valid = 1'b1; in_pixel = 8'h10; in_run = 8'd0;
    go();
    in_pixel = 8'h20; in_run = 8'd1;
    mid();
    expect_px("b2b.px0", 8'h10, 4, 1'b0);
    check("b2b.ready0", 32'(in_ready), 32'd1);
    go();
    in_pixel = 8'h30; in_run = 8'd0;
    mid();
    expect_px("b2b.px1", 8'h20, 5, 1'b0);
    check("b2b.ready1", 32'(in_ready), 32'd0);
    go();
    mid();
    expect_px("b2b.px2", 8'h20, 6, 1'b0);
    check("b2b.ready2", 32'(in_ready), 32'd1);
    go();
    in_valid = 1'b0;
    mid();
    expect_px("b2b.px3", 8'h30, 7, 1'b0);
    go();
    mid();
    check("b2b.end_valid", 32'(out_valid), 32'd0);

    // Backpressure with out_ready toggling.
    go();
    in_valid = 1'b1; in_pixel = 8'hFF; in_run = 8'd2;
    mid();
    check("bp.idle_ready", 32'(in_ready), 32'd1);
    go();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i][0];
      mid();
      expect_px($sformatf("bp.c%0d", i), 8'hFF, pos_pat[i], 1'b0);
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'(irdy_pat[i]));
      go();
    end
    out_ready = 1'b1;
    mid();
    check("bp.end_valid", 32'(out_valid), 32'd0);
    check("bp.end_pos",   32'(out_pos),   32'd11);

    // Block span from a fresh reset: 60 + 10 pixels across the 64-pixel boundary.
    go();
    rst = 1'b1;
    go();
    rst = 1'b0;
    mid();
    check("span.rst_pos", 32'(out_pos), 32'd0);
    in_valid = 1'b1; in_pixel = 8'h01; in_run = 8'd59;
    go();
    in_pixel = 8'h02; in_run = 8'd9;
    for (int i = 0; i < 70; i++) begin
      mid();
      expect_px($sformatf("span.px%0d", i), (i < 60) ? 8'h01 : 8'h02, i % 64, i == 63);
      check($sformatf("span.blk%0d", i), 32'(blocks_done), (i < 64) ? 32'd0 : 32'd1);
      accepted = in_valid & in_ready;
      go();
      if (accepted) in_valid = 1'b0;
    end
    mid();
    check("span.end_valid", 32'(out_valid),   32'd0);
    check("span.end_blk",   32'(blocks_done), 32'd1);
    check("span.end_pos",   32'(out_pos),     32'd6);

    // Max run, interrupted by reset after 100 pixels.
    go();
    in_valid = 1'b1; in_pixel = 8'hAA; in_run = 8'd255;
    go();
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      pos = (6 + i) % 64;
      mid();
      expect_px($sformatf("max.px%0d", i), 8'hAA, pos, pos == 63);
      check($sformatf("max.blk%0d", i), 32'(blocks_done), (i <= 57) ? 32'd1 : 32'd2);
      if (i % 25 == 0) check($sformatf("max.in_ready%0d", i), 32'(in_ready), 32'd0);
      go();
    end
    rst = 1'b1;
    mid();
    check("max.rst_in_ready", 32'(in_ready), 32'd0);
    go();
    rst = 1'b0;
    mid();
    check("max.post_valid", 32'(out_valid),   32'd0);
    check("max.post_pos",   32'(out_pos),     32'd0);
    check("max.post_blk",   32'(blocks_done), 32'd0);
    check("max.post_busy",  32'(busy),        32'd0);
    in_valid = 1'b1; in_pixel = 8'h3C; in_run = 8'd1;
    go();
    in_valid = 1'b0;
    mid();
    expect_px("after.px0", 8'h3C, 0, 1'b0);
    go();
    mid();
    expect_px("after.px1", 8'h3C, 1, 1'b0);
    go();
    mid();
    check("after.end_valid", 32'(out_valid), 32'd0);
    check("after.end_pos",   32'(out_pos),   32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
